// File: rtl/midi_rx_parser.sv
// MIDI receiver: 31250 baud 8N1 deframer plus running-status channel-voice parser.
// Ports: clk, reset (sync, active high), serial_rx (async line, idle high);
//   byte_valid/byte_data (deframed bytes), framing_err (stop bit low);
//   ev_valid/ev_type/ev_channel/ev_data1/ev_data2 (completed channel events).
module midi_rx_parser #(
    parameter int         CLKS_PER_BIT = 512,
    parameter bit         OMNI         = 1'b1,
    parameter logic [3:0] CHANNEL      = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_err,
    output logic       ev_valid,
    output logic [1:0] ev_type,
    output logic [3:0] ev_channel,
    output logic [6:0] ev_data1,
    output logic [6:0] ev_data2
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_e;

    logic          meta_q, sync_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          bv_q, bv_d, fe_q, fe_d;
    logic [7:0]    bd_q, bd_d;

    logic [7:0]    rs_q, rs_d;
    logic          rsv_q, rsv_d;
    logic          idx_q, idx_d;
    logic [6:0]    d1_q, d1_d;
    logic          evv_q, evv_d;
    logic [1:0]    evt_q, evt_d;
    logic [3:0]    evc_q, evc_d;
    logic [6:0]    evd1_q, evd1_d, evd2_q, evd2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
            bd_q    <= '0;
            rs_q    <= '0;
            rsv_q   <= 1'b0;
            idx_q   <= 1'b0;
            d1_q    <= '0;
            evv_q   <= 1'b0;
            evt_q   <= '0;
            evc_q   <= '0;
            evd1_q  <= '0;
            evd2_q  <= '0;
        end else begin
            meta_q  <= serial_rx;
            sync_q  <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
            bd_q    <= bd_d;
            rs_q    <= rs_d;
            rsv_q   <= rsv_d;
            idx_q   <= idx_d;
            d1_q    <= d1_d;
            evv_q   <= evv_d;
            evt_q   <= evt_d;
            evc_q   <= evc_d;
            evd1_q  <= evd1_d;
            evd2_q  <= evd2_d;
        end
    end

    // UART deframer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        bd_d    = bd_q;
        case (state_q)
            S_IDLE: begin
                if (!sync_q) begin
                    state_d = S_START;
                    cnt_d   = HALF;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!sync_q) begin
                    state_d = S_DATA;
                    cnt_d   = FULL;
                    bit_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {sync_q, shift_q[7:1]};
                    cnt_d   = FULL;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (sync_q) begin
                    bd_d    = shift_q;
                    bv_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    fe_d    = 1'b1;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                // Only a return to idle level re-arms start detection.
                if (sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Running-status parser
    logic is_rt, is_sys, is_stat, is_data;
    logic need1, done, chan_ok;

    always_comb begin
        is_rt   = bd_q[7:3] == 5'b11111;
        is_sys  = bd_q[7:3] == 5'b11110;
        is_stat = bd_q[7] && (bd_q[7:4] != 4'hF);
        is_data = !bd_q[7];
        need1   = (rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD);
        chan_ok = OMNI || (rs_q[3:0] == CHANNEL);
        done    = 1'b0;
        rs_d    = rs_q;
        rsv_d   = rsv_q;
        idx_d   = idx_q;
        d1_d    = d1_q;
        evv_d   = 1'b0;
        evt_d   = evt_q;
        evc_d   = evc_q;
        evd1_d  = evd1_q;
        evd2_d  = evd2_q;
        if (bv_q) begin
            unique case (1'b1)
                is_rt: ;
                is_sys: begin
                    rsv_d = 1'b0;
                    idx_d = 1'b0;
                end
                is_stat: begin
                    rs_d  = bd_q;
                    rsv_d = 1'b1;
                    idx_d = 1'b0;
                end
                is_data: begin
                    if (rsv_q) begin
                        if (!idx_q) begin
                            d1_d  = bd_q[6:0];
                            done  = need1;
                            idx_d = !need1;
                        end else begin
                            done  = 1'b1;
                            idx_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (done && chan_ok) begin
            evc_d  = rs_q[3:0];
            evd1_d = idx_q ? d1_q : bd_q[6:0];
            evd2_d = bd_q[6:0];
            case (rs_q[7:4])
                4'h8: begin evv_d = 1'b1; evt_d = 2'd0; end
                4'h9: begin
                    evv_d = 1'b1;
                    evt_d = (bd_q[6:0] != 7'd0) ? 2'd1 : 2'd0;
                end
                4'hB: begin evv_d = 1'b1; evt_d = 2'd2; end
                4'hE: begin evv_d = 1'b1; evt_d = 2'd3; end
                default: begin
                    evc_d  = evc_q;
                    evd1_d = evd1_q;
                    evd2_d = evd2_q;
                end
            endcase
        end
    end

    assign byte_valid  = bv_q;
    assign byte_data   = bd_q;
    assign framing_err = fe_q;
    assign ev_valid    = evv_q;
    assign ev_type     = evt_q;
    assign ev_channel  = evc_q;
    assign ev_data1    = evd1_q;
    assign ev_data2    = evd2_q;
endmodule

// File: tb/tb_midi_rx_parser.sv
// Bench for midi_rx_parser: two fast instances (omni / channel 3) on one line
// checked every cycle against a queue model, plus a 512-clock instance.
module tb_midi_rx_parser;
    localparam int CPB = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic rx_ab = 1'b1;
    logic rx_c  = 1'b1;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_bv, a_fe, a_ev, b_bv, b_fe, b_ev, c_bv, c_fe, c_ev;
    logic [7:0] a_bd, b_bd, c_bd;
    logic [1:0] a_t, b_t, c_t;
    logic [3:0] a_c, b_c, c_c;
    logic [6:0] a_d1, a_d2, b_d1, b_d2, c_d1, c_d2;

    midi_rx_parser #(.CLKS_PER_BIT(CPB), .OMNI(1'b1), .CHANNEL(4'd0)) dut_a (
        .clk(clk), .reset(reset), .serial_rx(rx_ab),
        .byte_valid(a_bv), .byte_data(a_bd), .framing_err(a_fe),
        .ev_valid(a_ev), .ev_type(a_t), .ev_channel(a_c),
        .ev_data1(a_d1), .ev_data2(a_d2));

    midi_rx_parser #(.CLKS_PER_BIT(CPB), .OMNI(1'b0), .CHANNEL(4'd3)) dut_b (
        .clk(clk), .reset(reset), .serial_rx(rx_ab),
        .byte_valid(b_bv), .byte_data(b_bd), .framing_err(b_fe),
        .ev_valid(b_ev), .ev_type(b_t), .ev_channel(b_c),
        .ev_data1(b_d1), .ev_data2(b_d2));

    midi_rx_parser #(.CLKS_PER_BIT(512), .OMNI(1'b1), .CHANNEL(4'd0)) dut_c (
        .clk(clk), .reset(reset), .serial_rx(rx_c),
        .byte_valid(c_bv), .byte_data(c_bd), .framing_err(c_fe),
        .ev_valid(c_ev), .ev_type(c_t), .ev_channel(c_c),
        .ev_data1(c_d1), .ev_data2(c_d2));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Model: expected bytes and events per fast instance.
    logic [7:0]  bq0[$], bq1[$];
    logic [19:0] eq0[$], eq1[$];
    logic [7:0]  exp_bd[2];
    logic [19:0] exp_ev[2];
    bit          prev_bv[2];
    int          fe_pend[2];
    int          m_status = -1;
    int          m_pend[$];

    task automatic emit(input int st, input int d1, input int d2);
        int hi, ch, ty;
        bit ok;
        logic [19:0] e;
        hi = st >> 4;
        ch = st & 15;
        ok = 1'b1;
        ty = 0;
        case (hi)
            8:  ty = 0;
            9:  ty = (d2 != 0) ? 1 : 0;
            11: ty = 2;
            14: ty = 3;
            default: ok = 1'b0;
        endcase
        if (ok) begin
            e = {ty[1:0], ch[3:0], d1[6:0], d2[6:0]};
            eq0.push_back(e);
            if (ch == 3) eq1.push_back(e);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int need, hi;
        if (b >= 8'hF8) begin
        end else if (b >= 8'hF0) begin
            m_status = -1;
            m_pend.delete();
        end else if (b[7]) begin
            m_status = int'(b);
            m_pend.delete();
        end else if (m_status >= 0) begin
            hi = m_status >> 4;
            need = (hi == 12 || hi == 13) ? 1 : 2;
            m_pend.push_back(int'(b));
            if (m_pend.size() == need) begin
                emit(m_status, m_pend[0], (need == 2) ? m_pend[1] : 0);
                m_pend.delete();
            end
        end
    endtask

    task automatic cmp(input int k, input logic bv, input logic [7:0] bd,
                       input logic fe, input logic evv, input logic [19:0] evf);
        string p;
        logic [7:0] eb;
        logic [19:0] ee;
        int n;
        p = (k == 0) ? "a" : "b";
        if (bv) begin
            n = (k == 0) ? bq0.size() : bq1.size();
            if (n == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_unexp_byte got=%0h exp=none", p, bd);
            end else begin
                if (k == 0) eb = bq0.pop_front();
                else        eb = bq1.pop_front();
                chk({p, "_byte"}, 32'(bd), 32'(eb));
                exp_bd[k] = eb;
            end
        end else begin
            chk({p, "_byte_hold"}, 32'(bd), 32'(exp_bd[k]));
        end
        if (fe) begin
            chk({p, "_fe_expected"}, 32'(fe_pend[k] > 0), 32'd1);
            if (fe_pend[k] > 0) fe_pend[k]--;
        end
        if (evv) begin
            chk({p, "_ev_latency"}, 32'(prev_bv[k]), 32'd1);
            n = (k == 0) ? eq0.size() : eq1.size();
            if (n == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_unexp_ev got=%0h exp=none", p, evf);
            end else begin
                if (k == 0) ee = eq0.pop_front();
                else        ee = eq1.pop_front();
                chk({p, "_ev"}, 32'(evf), 32'(ee));
                exp_ev[k] = ee;
            end
        end else begin
            chk({p, "_ev_hold"}, 32'(evf), 32'(exp_ev[k]));
        end
        prev_bv[k] = bv;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            cmp(0, a_bv, a_bd, a_fe, a_ev, {a_t, a_c, a_d1, a_d2});
            cmp(1, b_bv, b_bd, b_fe, b_ev, {b_t, b_c, b_d1, b_d2});
        end
    end

    // Slow instance monitor
    logic [7:0]  c_bytes[$];
    int          c_fe_n = 0, c_ev_n = 0, c_bv_cyc = 0, c_ev_cyc = 0;
    logic [19:0] c_evf = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (c_bv) begin
                c_bytes.push_back(c_bd);
                c_bv_cyc = cyc;
            end
            if (c_fe) c_fe_n++;
            if (c_ev) begin
                c_ev_n++;
                c_ev_cyc = cyc;
                c_evf = {c_t, c_c, c_d1, c_d2};
            end
        end
    end

    task automatic wcyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line(input bit to_c, input logic v);
        if (to_c) rx_c = v;
        else      rx_ab = v;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok,
                        input int cpb, input bit to_c);
        line(to_c, 1'b0);
        wcyc(cpb);
        for (int i = 0; i < 8; i++) begin
            line(to_c, b[i]);
            wcyc(cpb);
        end
        line(to_c, stop_ok);
        wcyc(cpb);
    endtask

    task automatic send_ab(input logic [7:0] b);
        bq0.push_back(b);
        bq1.push_back(b);
        model_byte(b);
        send(b, 1'b1, CPB, 1'b0);
        wcyc(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_ab = 1'b1;
        rx_c = 1'b1;
        m_status = -1;
        m_pend.delete();
        for (int k = 0; k < 2; k++) begin
            exp_bd[k] = '0;
            exp_ev[k] = '0;
            prev_bv[k] = 1'b0;
        end
        wcyc(3);
        reset = 1'b0;
    endtask

    logic [7:0] msgs[$];
    int n0, f0, e0;

    initial begin
        fe_pend[0] = 0;
        fe_pend[1] = 0;
        do_reset();
        @(negedge clk);
        chk("reset_outs_a", {a_bv, a_bd, a_fe, a_ev, a_t, a_c, a_d1, a_d2}, 32'd0);
        chk("reset_outs_c", {c_bv, c_bd, c_fe, c_ev, c_t, c_c, c_d1, c_d2}, 32'd0);
        wcyc(5);

        // Slow instance: full-rate note on
        send(8'h90, 1'b1, 512, 1'b1);
        send(8'h3C, 1'b1, 512, 1'b1);
        send(8'h64, 1'b1, 512, 1'b1);
        wcyc(10);
        chk("c_nbytes", c_bytes.size(), 3);
        if (c_bytes.size() == 3) begin
            chk("c_byte0", 32'(c_bytes[0]), 32'h90);
            chk("c_byte1", 32'(c_bytes[1]), 32'h3C);
            chk("c_byte2", 32'(c_bytes[2]), 32'h64);
        end
        chk("c_nev", c_ev_n, 1);
        chk("c_ev_lat", c_ev_cyc - c_bv_cyc, 1);
        chk("c_ev", 32'(c_evf), 32'({2'd1, 4'd0, 7'h3C, 7'h64}));
        // 100-cycle glitch is shorter than half a bit
        n0 = c_bytes.size();
        f0 = c_fe_n;
        e0 = c_ev_n;
        rx_c = 1'b0;
        wcyc(100);
        rx_c = 1'b1;
        wcyc(6000);
        chk("c_glitch_bytes", c_bytes.size(), n0);
        chk("c_glitch_fe", c_fe_n, f0);
        chk("c_glitch_ev", c_ev_n, e0);

        // Fast instances
        msgs = '{8'h90, 8'h3C, 8'h64};
        foreach (msgs[i]) send_ab(msgs[i]);
        chk("a_lit_noteon", {a_t, a_c, a_d1, a_d2}, 32'({2'd1, 4'd0, 7'h3C, 7'h64}));
        msgs = '{8'h91, 8'h40, 8'h7F, 8'h40, 8'h00};
        foreach (msgs[i]) send_ab(msgs[i]);
        chk("a_lit_rs_off", {a_t, a_c, a_d1, a_d2}, 32'({2'd0, 4'd1, 7'h40, 7'h00}));
        msgs = '{8'hB2, 8'h07, 8'hF8, 8'h55};
        foreach (msgs[i]) send_ab(msgs[i]);
        chk("a_lit_cc_rt", {a_t, a_c, a_d1, a_d2}, 32'({2'd2, 4'd2, 7'h07, 7'h55}));
        msgs = '{8'h80, 8'h30, 8'h00, 8'h83, 8'h30, 8'h00};
        foreach (msgs[i]) send_ab(msgs[i]);
        chk("b_lit_ch3", {b_t, b_c, b_d1, b_d2}, 32'({2'd0, 4'd3, 7'h30, 7'h00}));
        msgs = '{8'hF0, 8'h12, 8'h34, 8'hF7, 8'h40, 8'hC5, 8'h10,
                 8'hA3, 8'h10, 8'h20, 8'hD0, 8'h7F};
        foreach (msgs[i]) send_ab(msgs[i]);

        // Stop bit low, line stuck low
        fe_pend[0]++;
        fe_pend[1]++;
        send(8'h55, 1'b0, CPB, 1'b0);
        wcyc(5000);
        rx_ab = 1'b1;
        wcyc(10);
        chk("a_fe_seen", fe_pend[0], 0);
        msgs = '{8'hE0, 8'h00, 8'h40};
        foreach (msgs[i]) send_ab(msgs[i]);
        chk("a_lit_bend", {a_t, a_c, a_d1, a_d2}, 32'({2'd3, 4'd0, 7'h00, 7'h40}));

        // Short glitch on the fast line
        rx_ab = 1'b0;
        wcyc(8);
        rx_ab = 1'b1;
        wcyc(100);

        // Reset in the middle of 0x95's data bits
        rx_ab = 1'b0;
        wcyc(CPB);
        rx_ab = 1'b1;
        wcyc(CPB);
        rx_ab = 1'b0;
        wcyc(CPB);
        rx_ab = 1'b1;
        wcyc(CPB / 2);
        do_reset();
        @(negedge clk);
        chk("midrst_outs_a", {a_bv, a_bd, a_fe, a_ev, a_t, a_c, a_d1, a_d2}, 32'd0);
        chk("midrst_outs_b", {b_bv, b_bd, b_fe, b_ev, b_t, b_c, b_d1, b_d2}, 32'd0);
        wcyc(5);
        send_ab(8'h30);
        wcyc(50);

        chk("a_bytes_left", bq0.size(), 0);
        chk("b_bytes_left", bq1.size(), 0);
        chk("a_evs_left", eq0.size(), 0);
        chk("b_evs_left", eq1.size(), 0);
        chk("b_fe_seen", fe_pend[1], 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/midi_rx_parser.md
Name: midi_rx_parser

Overview:
Upstream input stage for the synth voice logic. It receives the raw MIDI serial line, which is 31250 baud 8N1 with idle high. It deframes bytes, applies MIDI running-status parsing and emits one-cycle channel-voice events (note off/on, control change, pitch bend). The events feed the note/voice allocation logic ahead of the mixer and PDM DAC.

Parameters:
CLKS_PER_BIT, 512, clk cycles per serial bit (16 MHz / 31250); must be even and >= 16
OMNI, 1, 1 = accept all channels; 0 = accept only CHANNEL
CHANNEL, 0, 4-bit MIDI channel (0-15) used when OMNI=0

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
serial_rx  input  1  asynchronous MIDI serial line, idle high
byte_valid  output  1  one-cycle pulse when a correctly framed byte is received
byte_data  output  8  last received byte; held until next byte_valid
framing_err  output  1  one-cycle pulse when the stop bit is sampled low
ev_valid  output  1  one-cycle pulse when an accepted channel event completes
ev_type  output  2  0 = note off, 1 = note on, 2 = control change, 3 = pitch bend
ev_channel  output  4  channel nibble of the status byte
ev_data1  output  7  note / controller number / bend LSB
ev_data2  output  7  velocity / controller value / bend MSB

Behaviour:
- Clock/reset: single clock `clk`; synchronous active-high `reset`, as already decided.
- On reset, all outputs are 0.
- Reset also clears the running status and the parser index, and returns the UART to IDLE.
- The synchronizer flops reset to 1, which is the idle level.
- Reset mid-frame abandons the frame with no pulse.

Input synchronizer:
- serial_rx passes through a 2-flop synchronizer.
- All UART logic uses the synchronized value.

UART FSM, states IDLE, START, DATA, STOP, WAIT_IDLE:
- IDLE: on synced low, go to START and load the bit counter.
- START: wait CLKS_PER_BIT/2 cycles, then resample the line.
  - Low: go to DATA; the sample point is now centred.
  - High: treat as a glitch and return to IDLE with no output.
- DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register.
- STOP: sample after CLKS_PER_BIT cycles.
  - High: byte_data <= shifted byte; byte_valid pulses on the next cycle; go to IDLE.
  - Low: framing_err pulses; byte_data is unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until synced line is high, then go to IDLE. A line stuck low yields exactly one framing_err.

Parser (acts only on byte_valid):
- Byte 0xF8-0xFF (realtime): ignored. Running status, index and latched data1 are untouched, so realtime may interleave mid-message.
- Byte 0xF0-0xF7: clear running status. Following data bytes are ignored until the next channel status byte (SysEx skip).
- Byte 0x80-0xEF: running_status <= byte; idx <= 0.
  - need = 1 for 0xC_/0xD_.
  - need = 2 otherwise.
- Data byte (bit7 = 0):
  - No running status: ignore.
  - idx = 0: latch data1. If need = 1, the message completes; otherwise idx <= 1.
  - idx = 1: the message completes; idx <= 0.
- Running status is retained after completion, so further data pairs form new messages with no repeated status byte.

Event emission on completion, registered: ev_valid pulses 1 cycle after the byte_valid of the completing byte.
- Emit only if OMNI = 1 or the status channel equals CHANNEL.
- 0x8_: type 0.
- 0x9_ with data2 != 0: type 1.
- 0x9_ with data2 = 0: type 0.
- 0xB_: type 2.
- 0xE_: type 3.
- 0xA_, 0xC_, 0xD_: consumed silently, no ev_valid.
- ev_* outputs hold their values until the next ev_valid.

Latency:
- Mid-stop-bit sample to byte_valid: 1 cycle.
- byte_valid to ev_valid: 1 cycle.

Test Plan:
- Send 0x90 0x3C 0x64 at CLKS_PER_BIT = 512 -> three byte_valid pulses with byte_data 0x90/0x3C/0x64. One ev_valid 1 cycle after the third, with type = 1, ch = 0, d1 = 0x3C, d2 = 0x64.
- Running status: 0x91 0x40 0x7F 0x40 0x00 -> two events: (type 1, ch 1, 0x40, 0x7F), then (type 0, ch 1, 0x40, 0x00).
- Realtime interleave: 0xB2 0x07 0xF8 0x55 -> one event (type 2, ch 2, 0x07, 0x55). The 0xF8 gives byte_valid only.
- OMNI = 0, CHANNEL = 3: 0x80 0x30 0x00, then 0x83 0x30 0x00 -> no event for the first message; event (type 0, ch 3, 0x30, 0x00) for the second.
- Framing error: frame with stop bit low, line then held low 5000 cycles -> exactly one framing_err, no byte_valid. Then 0xE0 0x00 0x40 -> event (type 3, d1 0x00, d2 0x40).
- Glitch/reset: 100-cycle low pulse -> no outputs. Reset asserted mid-DATA of 0x95 -> no pulses and outputs 0. A following data byte 0x30 is ignored because running status was cleared.
